sram_ctrl: RTL

//  Bridges the CPU data/instruction memory port inside thinpad_top to the two
//  off-chip 32-bit SRAM banks (BaseRAM, ExtRAM). It decodes the address, drives
//  the SRAM control strobes and tri-states the data bus. It answers with a
//  one-cycle ack. It sits directly upstream of the board SRAM chips.

---
 rtl/sram_pkg.sv | 27 ++
 rtl/sram_bank_drv.sv | 50 +++++
 rtl/sram_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared types for the SRAM controller: FSM states, bank select and the
// address windows of the two 4 MiB banks.
package sram_pkg;

  typedef enum logic [2:0] {IDLE, RD, WSETUP, WR, WHOLD, ACK} state_t;

  typedef enum logic [1:0] {SEL_NONE, SEL_BASE, SEL_EXT} bank_sel_t;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h8000_0000;
  localparam logic [31:0] DEF_EXT_ADDR  = 32'h8040_0000;
  localparam logic [31:0] WIN_SIZE      = 32'h0040_0000;

  // Offset compare keeps the window test to one subtract and one compare
  // per bank, and works for any window base.
  function automatic bank_sel_t decode_bank(input logic [31:0] a,
                                            input logic [31:0] base,
                                            input logic [31:0] ext);
    logic [31:0] off_b;
    logic [31:0] off_e;
    off_b = a - base;
    off_e = a - ext;
    if (off_b < WIN_SIZE)      return SEL_BASE;
    else if (off_e < WIN_SIZE) return SEL_EXT;
    else                       return SEL_NONE;
  endfunction

endpackage

// File: rtl/sram_bank_drv.sv
// Pin driver for one SRAM bank: registers the strobes, word address and
// byte enables, and owns the tri-state driver of the bank data bus.
module sram_bank_drv (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_n_d,
  input  logic        oe_n_d,
  input  logic        we_n_d,
  input  logic        drv_d,
  input  logic [3:0]  be_n_d,
  input  logic [19:0] addr_d,
  input  logic [31:0] wdata_d,
  output logic [31:0] rd_bus,
  inout  wire  [31:0] ram_data,
  output logic [19:0] ram_addr,
  output logic [3:0]  ram_be_n,
  output logic        ram_ce_n,
  output logic        ram_oe_n,
  output logic        ram_we_n
);

  logic        drv_q;
  logic [31:0] wdata_q;

  // Pin registers; the address only moves while the bank is selected so an
  // idle bank keeps a quiet address bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_ce_n <= 1'b1;
      ram_oe_n <= 1'b1;
      ram_we_n <= 1'b1;
      ram_be_n <= 4'hF;
      ram_addr <= '0;
      drv_q    <= 1'b0;
      wdata_q  <= '0;
    end else begin
      ram_ce_n <= ce_n_d;
      ram_oe_n <= oe_n_d;
      ram_we_n <= we_n_d;
      ram_be_n <= be_n_d;
      drv_q    <= drv_d;
      if (!ce_n_d) ram_addr <= addr_d;
      if (drv_d)   wdata_q  <= wdata_d;
    end
  end

  assign ram_data = drv_q ? wdata_q : {32{1'bz}};
  assign rd_bus   = ram_data;

endmodule

// File: rtl/sram_ctrl.sv
// CPU memory port to BaseRAM/ExtRAM bridge: address decode, access FSM with
// programmable strobe width, one-cycle ack.
// Optional: define SRAM_CTRL_RDBUF_EN for a one-entry read buffer that
// answers repeated reads of the same word without touching the SRAM.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter logic [31:0] EXT_ADDR    = DEF_EXT_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  inout  wire  [31:0] base_ram_data,
  output logic [19:0] base_ram_addr,
  output logic [3:0]  base_ram_be_n,
  output logic        base_ram_ce_n,
  output logic        base_ram_oe_n,
  output logic        base_ram_we_n,
  inout  wire  [31:0] ext_ram_data,
  output logic [19:0] ext_ram_addr,
  output logic [3:0]  ext_ram_be_n,
  output logic        ext_ram_ce_n,
  output logic        ext_ram_oe_n,
  output logic        ext_ram_we_n
);

  state_t      state, ns;
  logic [2:0]  cnt;
  logic [29:0] word_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  bank_sel_t   sel_q;

  // In IDLE the request fields come straight from the port so the first
  // strobe cycle can be registered on the accepting edge.
  logic        take;
  logic [29:0] cur_word;
  logic [3:0]  cur_be;
  logic [31:0] cur_wdata;
  bank_sel_t   cur_sel;

  assign take      = (state == IDLE);
  assign cur_word  = take ? addr[31:2] : word_q;
  assign cur_be    = take ? be         : be_q;
  assign cur_wdata = take ? wdata      : wdata_q;
  assign cur_sel   = take ? decode_bank(addr, BASE_ADDR, EXT_ADDR) : sel_q;

  logic last_wait;
  assign last_wait = (cnt == 3'(WAIT_CYCLES));

  logic [31:0] base_rd, ext_rd, bank_rd;
  assign bank_rd = (sel_q == SEL_EXT) ? ext_rd : base_rd;

  logic        rd_hit;
  logic [31:0] hit_data;

`ifdef SRAM_CTRL_RDBUF_EN
  logic        buf_vld;
  logic [29:0] buf_tag;
  logic [31:0] buf_data;

  assign rd_hit   = buf_vld && (buf_tag == addr[31:2]);
  assign hit_data = buf_data;

  // Read buffer: a completed SRAM read fills it, a completed write to the
  // tagged word merges its enabled bytes so the entry never goes stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_vld  <= 1'b0;
      buf_tag  <= '0;
      buf_data <= '0;
    end else if (state == RD && ns == ACK) begin
      buf_vld  <= 1'b1;
      buf_tag  <= word_q;
      buf_data <= bank_rd;
    end else if (state == WHOLD && buf_vld && buf_tag == word_q) begin
      for (int i = 0; i < 4; i++)
        if (be_q[i]) buf_data[8*i +: 8] <= wdata_q[8*i +: 8];
    end
  end
`else
  logic unused_word;
  assign rd_hit      = 1'b0;
  assign hit_data    = '0;
  assign unused_word = ^word_q[29:20];
`endif

  // Next-state logic; a req seen in ACK is left for the following IDLE cycle.
  always_comb begin
    ns = state;
    case (state)
      IDLE:   if (req) begin
                if (cur_sel == SEL_NONE) ns = ACK;
                else if (we)             ns = WSETUP;
                else if (rd_hit)         ns = ACK;
                else                     ns = RD;
              end
      RD:     if (last_wait) ns = ACK;
      WSETUP: ns = WR;
      WR:     if (last_wait) ns = WHOLD;
      WHOLD:  ns = ACK;
      ACK:    ns = IDLE;
      default: ns = IDLE;
    endcase
  end

  // State, strobe-width counter and the request latched at acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      word_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      sel_q   <= SEL_NONE;
    end else begin
      state <= ns;
      cnt   <= (ns == state && (state == RD || state == WR)) ? cnt + 3'd1 : 3'd0;
      if (take) begin
        word_q  <= addr[31:2];
        be_q    <= be;
        wdata_q <= wdata;
        sel_q   <= cur_sel;
      end
    end
  end

  // Response registers; read data is captured on the edge that leaves RD,
  // while the SRAM is still being strobed.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack   <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      ack <= (ns == ACK);
      err <= (ns == ACK) && (cur_sel == SEL_NONE);
      if (ns == ACK) begin
        if (state == RD)                           rdata <= bank_rd;
        else if (take && cur_sel != SEL_NONE)      rdata <= hit_data;
        else                                       rdata <= '0;
      end
    end
  end

  // Strobe values for the next cycle, gated per bank by the selection.
  logic       act_d, drv_d, oe_n_d, we_n_d, sel_b, sel_e;
  logic [3:0] be_n_d;

  assign act_d  = (ns == RD) || (ns == WSETUP) || (ns == WR) || (ns == WHOLD);
  assign drv_d  = (ns == WSETUP) || (ns == WR) || (ns == WHOLD);
  assign oe_n_d = (ns != RD);
  assign we_n_d = (ns != WR);
  assign be_n_d = (ns == RD) ? 4'h0 : (drv_d ? ~cur_be : 4'hF);
  assign sel_b  = (cur_sel == SEL_BASE);
  assign sel_e  = (cur_sel == SEL_EXT);

  sram_bank_drv u_base (
    .clk      (clk),
    .rst      (rst),
    .ce_n_d   (!(act_d && sel_b)),
    .oe_n_d   (oe_n_d || !sel_b),
    .we_n_d   (we_n_d || !sel_b),
    .drv_d    (drv_d && sel_b),
    .be_n_d   (sel_b ? be_n_d : 4'hF),
    .addr_d   (cur_word[19:0]),
    .wdata_d  (cur_wdata),
    .rd_bus   (base_rd),
    .ram_data (base_ram_data),
    .ram_addr (base_ram_addr),
    .ram_be_n (base_ram_be_n),
    .ram_ce_n (base_ram_ce_n),
    .ram_oe_n (base_ram_oe_n),
    .ram_we_n (base_ram_we_n)
  );

  sram_bank_drv u_ext (
    .clk      (clk),
    .rst      (rst),
    .ce_n_d   (!(act_d && sel_e)),
    .oe_n_d   (oe_n_d || !sel_e),
    .we_n_d   (we_n_d || !sel_e),
    .drv_d    (drv_d && sel_e),
    .be_n_d   (sel_e ? be_n_d : 4'hF),
    .addr_d   (cur_word[19:0]),
    .wdata_d  (cur_wdata),
    .rd_bus   (ext_rd),
    .ram_data (ext_ram_data),
    .ram_addr (ext_ram_addr),
    .ram_be_n (ext_ram_be_n),
    .ram_ce_n (ext_ram_ce_n),
    .ram_oe_n (ext_ram_oe_n),
    .ram_we_n (ext_ram_we_n)
  );

endmodule
